// File: rtl/sccb_config_seq_if.sv
// Command/response channel between the config sequencer and an SCCB master.
// One command in flight: valid/ready handshake out, single-cycle response pulse back.
interface sccb_config_seq_if #(
  parameter int REG_AW = 8,
  parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_rw;
   logic [REG_AW-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_nack;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
   );
endinterface

// File: rtl/sccb_config_seq.sv
// Walks a synchronous config ROM and issues SCCB register writes, with ms delays,
// optional read-back verify and bounded retry on NACK or mismatch.
module sccb_config_seq #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int ROM_AW    = 8,
  parameter int REG_AW    = 8,
  parameter int DATA_W    = 8,
  parameter int VERIFY    = 0,
  parameter int MAX_RETRY = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [ROM_AW-1:0]        rom_addr,
   input  logic [REG_AW+DATA_W-1:0] rom_data,
   sccb_config_seq_if.master        bus,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [ROM_AW-1:0]        err_count,
   output logic [ROM_AW-1:0]        err_index
);
   localparam int TICKS = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
   localparam int PW    = $clog2(TICKS + 1);

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R, DELAY, DONE
   } state_t;

   state_t            state;
   logic [ROM_AW-1:0] idx;
   logic [3:0]        retry;
   logic [PW-1:0]     pre;
   logic [DATA_W-1:0] ms_cnt;

   logic [REG_AW-1:0] ent_addr;
   logic [DATA_W-1:0] ent_data;
   logic              addr_ones, data_ones;
   logic              rd_bad, resp_fail, resp_ok, delay_end, zero_delay, advance;

   assign ent_addr  = rom_data[REG_AW+DATA_W-1 -: REG_AW];
   assign ent_data  = rom_data[DATA_W-1:0];
   assign addr_ones = &ent_addr;
   assign data_ones = &ent_data;

   // cmd_wdata holds the latched entry data, so it doubles as the verify reference
   assign rd_bad     = bus.rsp_nack || (bus.rsp_rdata != bus.cmd_wdata);
   assign resp_fail  = bus.rsp_valid && ((state == WAIT_W && bus.rsp_nack) ||
                                         (state == WAIT_R && rd_bad));
   assign resp_ok    = bus.rsp_valid && ((state == WAIT_W && !bus.rsp_nack && VERIFY == 0) ||
                                         (state == WAIT_R && !rd_bad));
   assign delay_end  = (state == DELAY) && (pre == PW'(TICKS - 1)) && (ms_cnt == DATA_W'(1));
   assign zero_delay = (state == DECODE) && addr_ones && !data_ones && (ent_data == '0);
   assign advance    = resp_ok || (resp_fail && retry == 4'd0) || delay_end || zero_delay;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         retry     <= '0;
         pre       <= '0;
         ms_cnt    <= '0;
         rom_addr  <= '0;
         bus.cmd_valid <= 1'b0;
         bus.cmd_rw    <= 1'b0;
         bus.cmd_addr  <= '0;
         bus.cmd_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
         err_index <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               idx       <= '0;
               rom_addr  <= '0;
               err       <= 1'b0;
               err_count <= '0;
               err_index <= '0;
               done      <= 1'b0;
               busy      <= 1'b1;
               state     <= FETCH;
            end
            FETCH: state <= DECODE;
            DECODE: begin
               bus.cmd_addr  <= ent_addr;
               bus.cmd_wdata <= ent_data;
               retry         <= 4'(MAX_RETRY);
               if (addr_ones && data_ones) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (addr_ones) begin
                  ms_cnt <= ent_data;
                  pre    <= '0;
                  state  <= DELAY;
               end else begin
                  bus.cmd_valid <= 1'b1;
                  bus.cmd_rw    <= 1'b0;
                  state         <= ISSUE_W;
               end
            end
            ISSUE_W, ISSUE_R: if (bus.cmd_ready) begin
               bus.cmd_valid <= 1'b0;
               state         <= (state == ISSUE_W) ? WAIT_W : WAIT_R;
            end
            WAIT_W, WAIT_R: begin
               if (resp_fail && retry != 4'd0) begin
                  retry         <= retry - 4'd1;
                  bus.cmd_valid <= 1'b1;
                  bus.cmd_rw    <= 1'b0;
                  state         <= ISSUE_W;
               end else if (state == WAIT_W && bus.rsp_valid && !bus.rsp_nack && VERIFY != 0) begin
                  bus.cmd_valid <= 1'b1;
                  bus.cmd_rw    <= 1'b1;
                  state         <= ISSUE_R;
               end
            end
            DELAY: begin
               if (pre == PW'(TICKS - 1)) begin
                  pre    <= '0;
                  ms_cnt <= ms_cnt - DATA_W'(1);
               end else begin
                  pre <= pre + PW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase

         // Entry exhausted its retries: log it, then move on like any other entry
         if (resp_fail && retry == 4'd0) begin
            err       <= 1'b1;
            err_index <= idx;
            if (!(&err_count)) err_count <= err_count + ROM_AW'(1);
         end

         if (advance) begin
            if (&idx) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end else begin
               idx      <= idx + ROM_AW'(1);
               rom_addr <= idx + ROM_AW'(1);
               state    <= FETCH;
            end
         end
      end
   end
endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench: DUT A (8-bit regs, no verify) runs a vector table plus delay/start/reset
// sequences; DUT B (16-bit regs, verify) checks read-back and mismatch retry.
module tb_sccb_config_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A ----------------
   logic        start_a;
   logic [2:0]  rom_addr_a, err_count_a, err_index_a;
   logic [15:0] rom_data_a;
   logic        busy_a, done_a, err_a;
   logic [15:0] rom_a [8];
   sccb_config_seq_if #(.REG_AW(8), .DATA_W(8)) bus_a ();

   sccb_config_seq #(.CLK_FREQ(1_000_000), .ROM_AW(3), .REG_AW(8), .DATA_W(8),
                     .VERIFY(0), .MAX_RETRY(3)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
      .bus(bus_a), .busy(busy_a), .done(done_a), .err(err_a),
      .err_count(err_count_a), .err_index(err_index_a));

   always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];

   // Slave A: logs writes, NACKs matching addresses for a scripted number of hits
   logic [7:0]  nack_addr;
   int          nack_n, hit_base_a;
   int          n_a = 0, hits_a = 0, wt_a = 0;
   logic        nack_q_a = 1'b0;
   logic [15:0] lg_a [512];
   int          lc_a [512];
   always @(posedge clk) begin
      if (bus_a.cmd_valid && bus_a.cmd_ready) begin
         lg_a[9'(n_a)] <= {bus_a.cmd_addr, bus_a.cmd_wdata};
         lc_a[9'(n_a)] <= cyc;
         n_a <= n_a + 1;
         if (nack_addr == 8'hFF || bus_a.cmd_addr == nack_addr) hits_a <= hits_a + 1;
         nack_q_a <= (nack_addr == 8'hFF || bus_a.cmd_addr == nack_addr) &&
                     ((hits_a - hit_base_a) < nack_n);
         wt_a <= 2;
      end else if (wt_a != 0) wt_a <= wt_a - 1;
      bus_a.rsp_valid <= (wt_a == 1);
      bus_a.rsp_nack  <= (wt_a == 1) && nack_q_a;
      bus_a.rsp_rdata <= 8'h00;
   end

   // ---------------- DUT B ----------------
   logic        start_b;
   logic [2:0]  rom_addr_b, err_count_b, err_index_b;
   logic [23:0] rom_data_b;
   logic        busy_b, done_b, err_b;
   logic [23:0] rom_b [8];
   sccb_config_seq_if #(.REG_AW(16), .DATA_W(8)) bus_b ();

   sccb_config_seq #(.CLK_FREQ(1_000_000), .ROM_AW(3), .REG_AW(16), .DATA_W(8),
                     .VERIFY(1), .MAX_RETRY(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
      .bus(bus_b), .busy(busy_b), .done(done_b), .err(err_b),
      .err_count(err_count_b), .err_index(err_index_b));

   always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

   // Slave B: always ACKs; reads return the last written data, optionally with bit 0 flipped
   logic        bad_read;
   int          n_b = 0, wt_b = 0;
   logic [7:0]  last_wd_b = 8'h00, rd_q_b = 8'h00;
   logic [24:0] lg_b [512];
   always @(posedge clk) begin
      if (bus_b.cmd_valid && bus_b.cmd_ready) begin
         lg_b[9'(n_b)] <= {bus_b.cmd_rw, bus_b.cmd_addr, bus_b.cmd_wdata};
         n_b <= n_b + 1;
         if (!bus_b.cmd_rw) last_wd_b <= bus_b.cmd_wdata;
         rd_q_b <= last_wd_b ^ {7'd0, bad_read};
         wt_b <= 2;
      end else if (wt_b != 0) wt_b <= wt_b - 1;
      bus_b.rsp_valid <= (wt_b == 1);
      bus_b.rsp_nack  <= 1'b0;
      bus_b.rsp_rdata <= rd_q_b;
   end

   // ---------------- checking ----------------
   int tests = 0, fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      string            name;
      logic [0:7][15:0] rom;
      logic [7:0]       na;
      int               nn;
      int               wr;
      logic             e;
      logic [2:0]       cnt;
      logic [2:0]       ix;
      logic [15:0]      first;
      logic [15:0]      last;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [0:7][15:0] r, input logic [7:0] na,
                               input int nn, input int wr, input logic e, input logic [2:0] c,
                               input logic [2:0] ix, input logic [15:0] f, input logic [15:0] l);
      vec_t v;
      v.name = nm; v.rom = r; v.na = na; v.nn = nn; v.wr = wr; v.e = e;
      v.cnt = c; v.ix = ix; v.first = f; v.last = l;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_a();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string nm, input int lim);
      int k = 0;
      while (!done_a && k < lim) begin @(negedge clk); k++; end
      chk({nm, "_done"}, 32'(done_a), 32'd1);
   endtask

   task automatic wait_done_b(input string nm, input int lim);
      int k = 0;
      while (!done_b && k < lim) begin @(negedge clk); k++; end
      chk({nm, "_done"}, 32'(done_b), 32'd1);
   endtask

   task automatic load_a(input logic [0:7][15:0] r);
      for (int j = 0; j < 8; j++) rom_a[j] = r[j];
   endtask

   vec_t tv [5];
   int   base, gap0, gap5, k;

   initial begin
      tv[0] = mk("three_writes",
                 {16'h1001, 16'h1102, 16'h1203, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                 8'h00, 0, 3, 1'b0, 3'd0, 3'd0, 16'h1001, 16'h1203);
      tv[1] = mk("nack2_then_ack",
                 {16'h20AA, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                 8'h20, 2, 3, 1'b0, 3'd0, 3'd0, 16'h20AA, 16'h20AA);
      tv[2] = mk("always_nack_mid",
                 {16'h3055, 16'h3166, 16'h3277, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                 8'h31, 255, 6, 1'b1, 3'd1, 3'd1, 16'h3055, 16'h3277);
      tv[3] = mk("no_end",
                 {16'h4000, 16'h4101, 16'h4202, 16'h4303, 16'h4404, 16'h4505, 16'h4606, 16'h4707},
                 8'h00, 0, 8, 1'b0, 3'd0, 3'd0, 16'h4000, 16'h4707);
      tv[4] = mk("all_nack_saturate",
                 {16'h7000, 16'h7101, 16'h7202, 16'h7303, 16'h7404, 16'h7505, 16'h7606, 16'h7707},
                 8'hFF, 255, 32, 1'b1, 3'd7, 3'd7, 16'h7000, 16'h7707);

      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      bus_a.cmd_ready = 1'b1; bus_b.cmd_ready = 1'b1;
      nack_addr = 8'h00; nack_n = 0; hit_base_a = 0; bad_read = 1'b0;
      for (int j = 0; j < 8; j++) begin rom_a[j] = 16'hFFFF; rom_b[j] = 24'hFFFFFF; end
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_rom_addr",  32'(rom_addr_a), 32'd0);
      chk("rst_cmd_valid", 32'(bus_a.cmd_valid), 32'd0);
      chk("rst_cmd_rw",    32'(bus_a.cmd_rw), 32'd0);
      chk("rst_cmd_addr",  32'(bus_a.cmd_addr), 32'd0);
      chk("rst_cmd_wdata", 32'(bus_a.cmd_wdata), 32'd0);
      chk("rst_busy_done", 32'({busy_a, done_a, err_a}), 32'd0);
      chk("rst_err_cnt",   32'({err_count_a, err_index_a}), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // table-driven scenarios on DUT A
      for (int i = 0; i < 5; i++) begin
         load_a(tv[i].rom);
         nack_addr = tv[i].na; nack_n = tv[i].nn; hit_base_a = hits_a;
         do_reset();
         base = n_a;
         pulse_a();
         wait_done_a(tv[i].name, 2000);
         chk({tv[i].name, "_busy"},   32'(busy_a), 32'd0);
         chk({tv[i].name, "_writes"}, 32'(n_a - base), 32'(tv[i].wr));
         chk({tv[i].name, "_err"},    32'(err_a), 32'(tv[i].e));
         chk({tv[i].name, "_errcnt"}, 32'(err_count_a), 32'(tv[i].cnt));
         chk({tv[i].name, "_erridx"}, 32'(err_index_a), 32'(tv[i].ix));
         chk({tv[i].name, "_first"},  32'(lg_a[9'(base)]), 32'(tv[i].first));
         chk({tv[i].name, "_last"},   32'(lg_a[9'(n_a - 1)]), 32'(tv[i].last));
      end
      nack_addr = 8'h00; nack_n = 0;

      // zero delay entry: handshake-to-handshake gap is the pure fetch/decode overhead
      load_a({16'h5001, 16'hFF00, 16'h5102, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      do_reset(); base = n_a; pulse_a();
      wait_done_a("delay0", 2000);
      chk("delay0_writes", 32'(n_a - base), 32'd2);
      gap0 = lc_a[9'(base + 1)] - lc_a[9'(base)];
      chk("delay0_gap", 32'(gap0), 32'd8);

      // 5 ms at 1 MHz adds 5000 cycles
      load_a({16'h5001, 16'hFF05, 16'h5102, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      do_reset(); base = n_a; pulse_a();
      wait_done_a("delay5", 8000);
      chk("delay5_writes", 32'(n_a - base), 32'd2);
      gap5 = lc_a[9'(base + 1)] - lc_a[9'(base)];
      tests++;
      if ((gap5 - gap0) < 4998 || (gap5 - gap0) > 5002) begin
         fails++;
         $display("FAIL delay5_len: got %0d extra cycles, expected 5000 +-2", gap5 - gap0);
      end

      // start while busy is ignored
      load_a({16'h6001, 16'hFF01, 16'h6102, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      do_reset(); base = n_a; pulse_a();
      chk("busy_rise", 32'(busy_a), 32'd1);
      k = 0;
      while (n_a == base && k < 50) begin @(negedge clk); k++; end
      repeat (10) @(negedge clk);
      chk("restart_busy", 32'(busy_a), 32'd1);
      pulse_a();
      wait_done_a("restart", 3000);
      chk("restart_writes", 32'(n_a - base), 32'd2);
      chk("restart_last", 32'(lg_a[9'(n_a - 1)]), 32'h6102);

      // reset while stalled in ISSUE_W
      load_a({16'h6203, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      bus_a.cmd_ready = 1'b0;
      do_reset(); pulse_a();
      k = 0;
      while (!bus_a.cmd_valid && k < 20) begin @(negedge clk); k++; end
      chk("stall_valid", 32'(bus_a.cmd_valid), 32'd1);
      chk("stall_addr",  32'({bus_a.cmd_addr, bus_a.cmd_wdata}), 32'h6203);
      repeat (3) @(negedge clk);
      chk("stall_hold", 32'(bus_a.cmd_valid), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(bus_a.cmd_valid), 32'd0);
      chk("midrst_cmd",   32'({bus_a.cmd_addr, bus_a.cmd_wdata}), 32'd0);
      chk("midrst_flags", 32'({busy_a, done_a, err_a}), 32'd0);
      chk("midrst_rom",   32'(rom_addr_a), 32'd0);
      rst = 1'b1;
      bus_a.cmd_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_idle", 32'({busy_a, bus_a.cmd_valid}), 32'd0);

      // DUT B: 16-bit address with verify; END after entry 0 must stop before entry 2
      rom_b[0] = 24'h300882; rom_b[1] = 24'hFFFFFF; rom_b[2] = 24'h123456;
      bad_read = 1'b0;
      do_reset(); base = n_b;
      start_b = 1'b1; @(negedge clk); start_b = 1'b0;
      wait_done_b("verify_ok", 2000);
      chk("verify_ok_hs",  32'(n_b - base), 32'd2);
      chk("verify_ok_wr",  32'(lg_b[9'(base)]), 32'h0300882);
      chk("verify_ok_rd",  32'(lg_b[9'(base + 1)][24:8]), 32'h13008);
      chk("verify_ok_err", 32'(err_b), 32'd0);

      bad_read = 1'b1;
      do_reset(); base = n_b;
      start_b = 1'b1; @(negedge clk); start_b = 1'b0;
      wait_done_b("verify_bad", 2000);
      chk("verify_bad_hs",  32'(n_b - base), 32'd8);
      chk("verify_bad_err", 32'({err_b, err_count_b, err_index_b}), 32'({1'b1, 3'd1, 3'd0}));
      chk("verify_bad_last", 32'(lg_b[9'(n_b - 1)][24:8]), 32'h13008);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sccb_config_seq.md
# sccb_config_seq

Parametrised register-list sequencer for SCCB/I2C camera sensors and the generalised successor of the fixed 8-bit OV7670 configuration sequencer. It walks a synchronous configuration ROM and issues write commands to the SCCB master through a valid/ready command channel. It also supports 8- or 16-bit register addresses (OV5640-class sensors), variable millisecond delay entries, optional read-back verify, and bounded retry on NACK or mismatch. It sits between the config ROM and the SCCB master, and is kicked once after sensor power-up.

## Interface
- CLK_FREQ, 25_000_000, clock frequency in Hz; sets delay-tick length.
- ROM_AW, 8, ROM address width.
- REG_AW, 8, register address width, 8 or 16.
- DATA_W, 8, register data width.
- VERIFY, 0, 1 = read back each written register and compare.
- MAX_RETRY, 3, extra attempts per entry after the first attempt fails (0..15).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- rom_addr  out  ROM_AW  ROM address; ROM returns data one cycle later.
- rom_data  in  REG_AW+DATA_W  {reg_addr, reg_data}.
- cmd_valid  out  1  command to SCCB master valid.
- cmd_ready  in  1  SCCB master accepts command.
- cmd_rw  out  1  0 = write, 1 = read.
- cmd_addr  out  REG_AW  register address.
- cmd_wdata  out  DATA_W  write data.
- rsp_valid  in  1  one-cycle transaction completion pulse.
- rsp_nack  in  1  qualified by rsp_valid; slave NACKed.
- rsp_rdata  in  DATA_W  qualified by rsp_valid; read data.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished; held until next accepted start.
- err  out  1  at least one entry exhausted its retries; cleared on start.
- err_count  out  ROM_AW  number of failed entries, saturating.
- err_index  out  ROM_AW  ROM index of the most recent failed entry.

## Operation
- Entry decode, with all-ones fields:
  - addr = all-ones and data = all-ones: END.
  - addr = all-ones, other data: DELAY of data ms; data = 0 means zero delay, go straight to the next entry.
  - Otherwise: register write.
- States: IDLE, FETCH, DECODE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R, DELAY, DONE.
- IDLE:
  - On start, clear idx, err, err_count and err_index; drop done; go to FETCH.
  - start while busy is ignored.
- FETCH: drive rom_addr = idx; go to DECODE.
- DECODE:
  - Latch rom_data; load retry counter = MAX_RETRY.
  - Branch to DONE, DELAY or ISSUE_W.
- ISSUE_W:
  - cmd_valid=1, cmd_rw=0; addr/data stable while cmd_valid.
  - Leave on the cycle cmd_valid & cmd_ready; go to WAIT_W.
- WAIT_W: on rsp_valid:
  - NACK: go to the failure path.
  - ACK with VERIFY=1: go to ISSUE_R.
  - ACK with VERIFY=0: go to advance.
- ISSUE_R: same handshake as ISSUE_W with cmd_rw=1; go to WAIT_R.
- WAIT_R: on rsp_valid:
  - NACK, or rsp_rdata != latched data: go to the failure path.
  - Otherwise: go to advance.
- Failure path:
  - Retry counter > 0: decrement, return to ISSUE_W.
  - Retry counter = 0: set err, err_index = idx, err_count += 1 (saturating at all-ones), then advance.
- Advance:
  - idx = 2^ROM_AW-1: go to DONE; no wrap.
  - Otherwise: idx+1, go to FETCH.
- DELAY:
  - Counts data × (CLK_FREQ/1000) cycles using a millisecond prescaler and a DATA_W-bit ms counter.
  - Then advance.
- DONE: done=1, busy=0; go to IDLE.
- rsp_valid outside WAIT_W/WAIT_R is ignored.

## Timing
- Reset values: rom_addr=0, cmd_valid=0, cmd_rw=0, cmd_addr=0, cmd_wdata=0, busy=0, done=0, err=0, err_count=0, err_index=0; state IDLE.
- busy rises the cycle after start is sampled and stays high through the last cycle before DONE.
- ROM latency is 1 cycle: rom_addr is presented in FETCH and rom_data is sampled in DECODE.
- A write entry reaches cmd_valid 3 cycles after the FETCH of its index.
- cmd_valid never drops before the handshake completes.
- Only one command is outstanding at a time.
- A DELAY of N ms lasts N·CLK_FREQ/1000 cycles (±2) from DECODE to the next FETCH.
- Synchronous reset mid-transaction forces IDLE next edge: cmd_valid=0, outputs to reset values; the in-flight response is ignored.

## Test plan
- 3 writes + END, always ACK, VERIFY=0: exactly 3 write handshakes with matching addr/data; done=1, err=0.
- REG_AW=16, entry {16'h3008, 8'h82}: cmd_addr=16'h3008, cmd_wdata=8'h82; END detected on 24'hFFFFFF.
- Entry {FF, 05} at CLK_FREQ=1_000_000: 5000 ±2 cycles between DECODE and the next FETCH; {FF, 00} gives no delay.
- NACK twice then ACK, MAX_RETRY=3: 3 write attempts, err=0. Always NACK: 4 attempts, err=1, err_index=entry, err_count=1, and the sequence continues.
- VERIFY=1, read returns data^1: retried to exhaustion, err=1. Correct read: write followed by read of the same addr.
- ROM without END: stops at index 2^ROM_AW-1 with done=1. start during busy is ignored. rst low mid-ISSUE_W: cmd_valid=0 next cycle, all outputs at reset values.
